// File: rtl/micro_apb_pkg.sv
// rtl/micro_apb_pkg.sv - shared types and constants for the micro APB initiator
package micro_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int CNT_W  = 16;
  localparam int APB_DW = 32;

endpackage

// File: rtl/micro_apb_master.sv
// rtl/micro_apb_master.sv - valid/ready request port to APB SETUP/ACCESS initiator with timeout
module micro_apb_master
  import micro_apb_pkg::*;
#(
  parameter int AW      = 4,
  parameter int DW      = APB_DW,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          apb_psel,
  output logic          apb_penable,
  output logic          apb_pwrite,
  output logic [AW-1:0] apb_paddr,
  output logic [DW-1:0] apb_pwdata,
  input  logic [DW-1:0] apb_prdata,
  input  logic          apb_pready
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam bit               TO_EN     = (TIMEOUT != 0);

  apb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             psel_q, psel_d;
  logic             penable_q, penable_d;
  logic             pwrite_q, pwrite_d;
  logic [AW-1:0]    paddr_q, paddr_d;
  logic [DW-1:0]    pwdata_q, pwdata_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  // The only unregistered output: IDLE is the sole accepting state.
  assign req_ready = (state_q == ST_IDLE) && !reset;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          pwrite_d = req_write;
          paddr_d  = req_addr;
          pwdata_d = req_wdata;
          psel_d   = 1'b1;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (apb_pready) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : apb_prdata;
          state_d     = ST_IDLE;
        end else if (TO_EN && (cnt_q == TIMEOUT_C)) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = ST_IDLE;
        end else begin
          // Saturate so TIMEOUT=0 can wait forever without wrapping.
          psel_d    = 1'b1;
          penable_d = 1'b1;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign apb_psel    = psel_q;
  assign apb_penable = penable_q;
  assign apb_pwrite  = pwrite_q;
  assign apb_paddr   = paddr_q;
  assign apb_pwdata  = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;

endmodule
